universal_shift_reg: RTL and testbench



---
 rtl/universal_shift_reg.sv | 147 ++++++++++++++
 tb/tb_universal_shift_reg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, logical/arithmetic shift, rotate and
// parallel load, moving STEP bits per operation. A small burst engine runs
// a latched shift/rotate mode for burst_len enabled cycles from a single
// start command and reports busy/done.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [STEP-1:0]  sin,
   input  logic [WIDTH-1:0] load_data,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] out,
   output logic [STEP-1:0]  sout_msb,
   output logic [STEP-1:0]  sout_lsb,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_SAR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_LOAD = 3'b110;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [2:0]       burst_mode;
   logic [2:0]       next_burst_mode;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] next_count;
   logic [WIDTH-1:0] next_out;
   logic             done_reg;
   logic             next_done;
   logic [2:0]       op_mode;
   logic [WIDTH-1:0] op_result;
   logic             is_shift_mode;

   // One register-update operation for a given mode; reserved codes hold.
   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] v,
      input logic [STEP-1:0]  s,
      input logic [WIDTH-1:0] ld
   );
      logic [WIDTH-1:0] r;
      case (m)
         MODE_SHL:  r = {v[WIDTH-STEP-1:0], s};
         MODE_SHR:  r = {s, v[WIDTH-1:STEP]};
         MODE_SAR:  r = {{STEP{v[WIDTH-1]}}, v[WIDTH-1:STEP]};
         MODE_ROL:  r = {v[WIDTH-STEP-1:0], v[WIDTH-1 -: STEP]};
         MODE_ROR:  r = {v[STEP-1:0], v[WIDTH-1:STEP]};
         MODE_LOAD: r = ld;
         default:   r = v;
      endcase
      return r;
   endfunction

   // During a burst the latched mode drives the datapath so that the live
   // mode input can change freely without disturbing the burst.
   always_comb begin
      op_mode       = (state == BURST) ? burst_mode : mode;
      op_result     = apply_op(op_mode, out, sin, load_data);
      is_shift_mode = (mode >= MODE_SHL) && (mode <= MODE_ROR);
   end

   // State register together with the shift register, burst counter and
   // the registered completion pulse; reset clears everything immediately,
   // so a burst cut short by reset never produces a done pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         out        <= '0;
         count      <= '0;
         burst_mode <= MODE_HOLD;
         done_reg   <= 1'b0;
      end else begin
         state      <= next_state;
         out        <= next_out;
         count      <= next_count;
         burst_mode <= next_burst_mode;
         done_reg   <= next_done;
      end
   end

   // Next-state logic. A start edge only latches the burst parameters and
   // does no operation; a burst that would do nothing (zero length or a
   // non-shift mode) completes at once with a done pulse. done defaults low
   // so it clears on the following edge whether or not en is high.
   always_comb begin
      next_state      = state;
      next_out        = out;
      next_count      = count;
      next_burst_mode = burst_mode;
      next_done       = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               if (burst_start) begin
                  next_burst_mode = mode;
                  if (is_shift_mode && (burst_len != '0)) begin
                     next_state = BURST;
                     next_count = burst_len;
                  end else begin
                     next_done = 1'b1;
                  end
               end else begin
                  next_out = op_result;
               end
            end
         end
         BURST: begin
            if (en) begin
               next_out   = op_result;
               next_count = count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  next_state = IDLE;
                  next_done  = 1'b1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs: busy follows the state directly, the serial taps are plain
   // slices of the register with no added latency.
   always_comb begin
      busy     = (state == BURST);
      done     = done_reg;
      sout_msb = out[WIDTH-1 -: STEP];
      sout_lsb = out[STEP-1:0];
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg: one instance with STEP=1 and one with
// STEP=2 share every input except the serial input. Directed table vectors,
// hand-written burst sequences and a randomized phase checked against an
// arithmetic reference model.
module tb_universal_shift_reg;

   logic       clk;
   logic       rstn;
   logic       en;
   logic [2:0] mode;
   logic       sin1;
   logic [1:0] sin2;
   logic [7:0] loadData;
   logic       burstStart;
   logic [3:0] burstLen;

   logic [7:0] out1;
   logic [0:0] msb1;
   logic [0:0] lsb1;
   logic       busy1;
   logic       done1;
   logic [7:0] out2;
   logic [1:0] msb2;
   logic [1:0] lsb2;
   logic       busy2;
   logic       done2;

   int testsRun;
   int testsFailed;

   int mOut[2];
   int mBusy[2];
   int mDone[2];
   int mRem[2];
   int mMode[2];

   typedef struct {
      logic       en;
      logic [2:0] mode;
      logic       sin1;
      logic [1:0] sin2;
      logic [7:0] load;
      logic [7:0] exp1;
      logic [7:0] exp2;
   } vec_t;

   vec_t vecs[18];

   universal_shift_reg #(.WIDTH(8), .STEP(1), .CNT_W(4)) dut1 (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode), .sin(sin1),
      .load_data(loadData), .burst_start(burstStart), .burst_len(burstLen),
      .out(out1), .sout_msb(msb1), .sout_lsb(lsb1), .busy(busy1), .done(done1)
   );

   universal_shift_reg #(.WIDTH(8), .STEP(2), .CNT_W(4)) dut2 (
      .clk(clk), .rstn(rstn), .en(en), .mode(mode), .sin(sin2),
      .load_data(loadData), .burst_start(burstStart), .burst_len(burstLen),
      .out(out2), .sout_msb(msb2), .sout_lsb(lsb2), .busy(busy2), .done(done2)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference result of one operation on an 8-bit value, written as plain
   // arithmetic on integers.
   function automatic int refOp(int m, int v, int s, int st, int ld);
      case (m)
         1: return ((v << st) | s) & 255;
         2: return (v >> st) | (s << (8 - st));
         3: return (v >> st) | (((v & 128) != 0) ? (255 ^ (255 >> st)) : 0);
         4: return ((v << st) | (v >> (8 - st))) & 255;
         5: return ((v >> st) | (v << (8 - st))) & 255;
         6: return ld;
         default: return v;
      endcase
   endfunction

   task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mOut[i]  = 0;
         mBusy[i] = 0;
         mDone[i] = 0;
         mRem[i]  = 0;
         mMode[i] = 0;
      end
   endtask

   // Drive one cycle of inputs, advance the reference model with the same
   // inputs, then step past the rising edge.
   task automatic applyStimulus(input int e, input int m, input int s1, input int s2,
                                input int ld, input int bst, input int blen);
      int s;
      en         = 1'(e);
      mode       = 3'(m);
      sin1       = 1'(s1);
      sin2       = 2'(s2);
      loadData   = 8'(ld);
      burstStart = 1'(bst);
      burstLen   = 4'(blen);
      for (int i = 0; i < 2; i++) begin
         s = (i == 0) ? s1 : s2;
         mDone[i] = 0;
         if (mBusy[i] == 0) begin
            if (e != 0) begin
               if (bst != 0) begin
                  if (m >= 1 && m <= 5 && blen > 0) begin
                     mBusy[i] = 1;
                     mRem[i]  = blen;
                     mMode[i] = m;
                  end else begin
                     mDone[i] = 1;
                  end
               end else begin
                  mOut[i] = refOp(m, mOut[i], s, i + 1, ld);
               end
            end
         end else if (e != 0) begin
            mOut[i] = refOp(mMode[i], mOut[i], s, i + 1, ld);
            mRem[i] = mRem[i] - 1;
            if (mRem[i] == 0) begin
               mBusy[i] = 0;
               mDone[i] = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: asserted between edges, checked before any edge,
   // released just after the falling edge.
   task automatic applyReset(input string name);
      en         = 1'b0;
      burstStart = 1'b0;
      rstn       = 1'b0;
      modelReset();
      #3;
      compareValue({name, ".out1"}, 32'(out1), 32'h0);
      compareValue({name, ".out2"}, 32'(out2), 32'h0);
      compareValue({name, ".busy1"}, 32'(busy1), 32'h0);
      compareValue({name, ".busy2"}, 32'(busy2), 32'h0);
      compareValue({name, ".done1"}, 32'(done1), 32'h0);
      compareValue({name, ".done2"}, 32'(done2), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Hand-computed expectation for the STEP=1 register plus the shared
   // burst handshake; the STEP=2 register is held to the model.
   task automatic checkOutput(input string name, input int exp1, input int expBusy, input int expDone);
      compareValue({name, ".out1"}, 32'(out1), 32'(exp1));
      compareValue({name, ".busy1"}, 32'(busy1), 32'(expBusy));
      compareValue({name, ".done1"}, 32'(done1), 32'(expDone));
      compareValue({name, ".busy2"}, 32'(busy2), 32'(expBusy));
      compareValue({name, ".done2"}, 32'(done2), 32'(expDone));
      compareValue({name, ".out2"}, 32'(out2), 32'(mOut[1]));
   endtask

   task automatic checkModel(input string name);
      compareValue({name, ".out1"}, 32'(out1), 32'(mOut[0]));
      compareValue({name, ".busy1"}, 32'(busy1), 32'(mBusy[0]));
      compareValue({name, ".done1"}, 32'(done1), 32'(mDone[0]));
      compareValue({name, ".msb1"}, 32'(msb1), 32'(mOut[0] >> 7));
      compareValue({name, ".lsb1"}, 32'(lsb1), 32'(mOut[0] & 1));
      compareValue({name, ".out2"}, 32'(out2), 32'(mOut[1]));
      compareValue({name, ".busy2"}, 32'(busy2), 32'(mBusy[1]));
      compareValue({name, ".done2"}, 32'(done2), 32'(mDone[1]));
      compareValue({name, ".msb2"}, 32'(msb2), 32'(mOut[1] >> 6));
      compareValue({name, ".lsb2"}, 32'(lsb2), 32'(mOut[1] & 3));
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rstn        = 1'b0;
      en          = 1'b0;
      mode        = 3'd0;
      sin1        = 1'b0;
      sin2        = 2'd0;
      loadData    = 8'h00;
      burstStart  = 1'b0;
      burstLen    = 4'd0;

      //           en    mode  sin1  sin2   load   exp1   exp2
      vecs[0]  = '{1'b1, 3'd6, 1'b0, 2'd0, 8'hA5, 8'hA5, 8'hA5};
      vecs[1]  = '{1'b1, 3'd1, 1'b1, 2'd3, 8'h00, 8'h4B, 8'h97};
      vecs[2]  = '{1'b1, 3'd6, 1'b0, 2'd0, 8'hA5, 8'hA5, 8'hA5};
      vecs[3]  = '{1'b1, 3'd2, 1'b0, 2'd0, 8'h00, 8'h52, 8'h29};
      vecs[4]  = '{1'b1, 3'd6, 1'b0, 2'd0, 8'hA5, 8'hA5, 8'hA5};
      vecs[5]  = '{1'b1, 3'd3, 1'b1, 2'd3, 8'h00, 8'hD2, 8'hE9};
      vecs[6]  = '{1'b1, 3'd6, 1'b0, 2'd0, 8'h81, 8'h81, 8'h81};
      vecs[7]  = '{1'b1, 3'd5, 1'b1, 2'd3, 8'h00, 8'hC0, 8'h60};
      vecs[8]  = '{1'b0, 3'd1, 1'b1, 2'd3, 8'hFF, 8'hC0, 8'h60};
      vecs[9]  = '{1'b0, 3'd6, 1'b0, 2'd0, 8'hFF, 8'hC0, 8'h60};
      vecs[10] = '{1'b1, 3'd6, 1'b0, 2'd0, 8'hB4, 8'hB4, 8'hB4};
      vecs[11] = '{1'b1, 3'd1, 1'b1, 2'd3, 8'h00, 8'h69, 8'hD3};
      vecs[12] = '{1'b1, 3'd6, 1'b0, 2'd0, 8'hB4, 8'hB4, 8'hB4};
      vecs[13] = '{1'b1, 3'd5, 1'b0, 2'd0, 8'h00, 8'h5A, 8'h2D};
      vecs[14] = '{1'b1, 3'd7, 1'b1, 2'd3, 8'hFF, 8'h5A, 8'h2D};
      vecs[15] = '{1'b1, 3'd0, 1'b1, 2'd3, 8'hFF, 8'h5A, 8'h2D};
      vecs[16] = '{1'b1, 3'd4, 1'b0, 2'd0, 8'h00, 8'hB4, 8'hB4};
      vecs[17] = '{1'b1, 3'd2, 1'b1, 2'd2, 8'h00, 8'hDA, 8'hAD};

      applyReset("reset");

      for (int i = 0; i < 18; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         applyStimulus(int'(vecs[i].en), int'(vecs[i].mode), int'(vecs[i].sin1),
                       int'(vecs[i].sin2), int'(vecs[i].load), 0, 0);
         compareValue({tag, ".out1"}, 32'(out1), 32'(vecs[i].exp1));
         compareValue({tag, ".out2"}, 32'(out2), 32'(vecs[i].exp2));
         compareValue({tag, ".msb1"}, 32'(msb1), 32'(vecs[i].exp1 >> 7));
         compareValue({tag, ".lsb1"}, 32'(lsb1), 32'(vecs[i].exp1 & 8'h01));
         compareValue({tag, ".msb2"}, 32'(msb2), 32'(vecs[i].exp2 >> 6));
         compareValue({tag, ".lsb2"}, 32'(lsb2), 32'(vecs[i].exp2 & 8'h03));
         compareValue({tag, ".busy1"}, 32'(busy1), 32'h0);
         compareValue({tag, ".done1"}, 32'(done1), 32'h0);
      end

      // Burst ROL x3 with the mode input wandering during the burst.
      applyStimulus(1, 6, 0, 0, 8'h01, 0, 0);
      checkOutput("b1_load", 8'h01, 0, 0);
      applyStimulus(1, 4, 0, 0, 8'h00, 1, 3);
      checkOutput("b1_start", 8'h01, 1, 0);
      applyStimulus(1, 1, 1, 3, 8'hFF, 1, 5);
      checkOutput("b1_s1", 8'h02, 1, 0);
      applyStimulus(1, 6, 1, 3, 8'hFF, 0, 0);
      checkOutput("b1_s2", 8'h04, 1, 0);
      applyStimulus(1, 2, 1, 3, 8'hFF, 0, 0);
      checkOutput("b1_s3", 8'h08, 0, 1);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("b1_after", 8'h08, 0, 0);

      // Burst paused for two cycles by en low.
      applyStimulus(1, 6, 0, 0, 8'h01, 0, 0);
      applyStimulus(1, 4, 0, 0, 8'h00, 1, 3);
      checkOutput("b2_start", 8'h01, 1, 0);
      applyStimulus(1, 4, 0, 0, 8'h00, 0, 0);
      checkOutput("b2_s1", 8'h02, 1, 0);
      applyStimulus(0, 1, 1, 3, 8'h00, 1, 7);
      checkOutput("b2_pause1", 8'h02, 1, 0);
      applyStimulus(0, 1, 1, 3, 8'h00, 0, 0);
      checkOutput("b2_pause2", 8'h02, 1, 0);
      applyStimulus(1, 4, 0, 0, 8'h00, 0, 0);
      checkOutput("b2_s2", 8'h04, 1, 0);
      applyStimulus(1, 4, 0, 0, 8'h00, 0, 0);
      checkOutput("b2_s3", 8'h08, 0, 1);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("b2_after", 8'h08, 0, 0);

      // Zero length, LOAD-mode start, then a back-to-back start while done is high.
      applyStimulus(1, 4, 0, 0, 8'h00, 1, 0);
      checkOutput("zero_len", 8'h08, 0, 1);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("zero_after", 8'h08, 0, 0);
      applyStimulus(1, 6, 0, 0, 8'hFF, 1, 3);
      checkOutput("load_burst", 8'h08, 0, 1);
      applyStimulus(1, 5, 0, 0, 8'h00, 1, 1);
      checkOutput("b2b_start", 8'h08, 1, 0);
      applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
      checkOutput("b2b_s1", 8'h04, 0, 1);

      // Reset in the middle of an SHL x5 burst, then a clean burst.
      applyStimulus(1, 6, 0, 0, 8'h81, 0, 0);
      applyStimulus(1, 1, 0, 0, 8'h00, 1, 5);
      checkOutput("rb_start", 8'h81, 1, 0);
      applyStimulus(1, 1, 0, 0, 8'h00, 0, 0);
      checkOutput("rb_s1", 8'h02, 1, 0);
      applyStimulus(1, 1, 0, 0, 8'h00, 0, 0);
      checkOutput("rb_s2", 8'h04, 1, 0);
      applyReset("rb_reset");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
         checkOutput("rb_idle", 8'h00, 0, 0);
      end
      applyStimulus(1, 6, 0, 0, 8'h03, 0, 0);
      applyStimulus(1, 2, 1, 0, 8'h00, 1, 2);
      checkOutput("rb2_start", 8'h03, 1, 0);
      applyStimulus(1, 2, 1, 0, 8'h00, 0, 0);
      checkOutput("rb2_s1", 8'h81, 1, 0);
      applyStimulus(1, 2, 1, 0, 8'h00, 0, 0);
      checkOutput("rb2_s2", 8'hC0, 0, 1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            applyReset("rand_reset");
         end else begin
            applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0,
                          int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)),
                          ($urandom_range(0, 7) == 0) ? 1 : 0,
                          int'($urandom_range(0, 15)));
         end
         checkModel("rand");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
